// File: rtl/axi_rr_txn_arbiter.sv
// axi_rr_txn_arbiter: round-robin owner of one shared AXI slave port, holding the grant
// until its address quota is spent or it stops requesting, then draining its responses.
module axi_rr_txn_arbiter #(
    parameter int N_REQ     = 2,
    parameter int MAX_OUTST = 4,
    parameter int QUOTA     = 8,
    parameter int IDX_W     = $clog2(N_REQ),
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             addr_hs_i,
    input  logic             resp_done_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o,
    output logic [CNT_W-1:0] outst_cnt_o,
    output logic             busy_o,
    output logic             err_o
);
    localparam int QW = $clog2(QUOTA + 1);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t           r_state, w_state_nx;
    logic [IDX_W-1:0] r_idx, r_ptr, w_sel;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [QW-1:0]    r_quota, w_q_nx;
    logic             r_err, w_gv, w_hs, w_rd, w_any;

    assign w_gv     = (r_state == GRANT) && (r_cnt < CNT_W'(MAX_OUTST)) && (r_quota < QW'(QUOTA));
    assign w_hs     = addr_hs_i && w_gv;
    // a response paired with a same-cycle handshake is legal even at count zero
    assign w_rd     = resp_done_i && (r_cnt != '0 || w_hs);
    assign w_cnt_nx = r_cnt + CNT_W'(w_hs) - CNT_W'(w_rd);
    assign w_q_nx   = r_quota + QW'(w_hs);

    // lowest offset from ptr+1 wins, so iterate from the farthest and overwrite
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req_i[(int'(r_ptr) + i) % N_REQ]) begin
                w_sel = IDX_W'((int'(r_ptr) + i) % N_REQ);
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nx = GRANT;
            GRANT:   if (!req_i[r_idx] || w_q_nx == QW'(QUOTA))
                         w_state_nx = (w_cnt_nx != '0) ? DRAIN : IDLE;
            DRAIN:   if (w_cnt_nx == '0) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_ptr   <= IDX_W'(N_REQ - 1);
            r_cnt   <= '0;
            r_quota <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_quota <= (r_state == IDLE) ? '0 : w_q_nx;
            if (r_state == IDLE && w_any) begin
                r_idx <= w_sel;
                r_ptr <= w_sel;
            end
            r_err   <= r_err | (addr_hs_i && !w_gv) | (resp_done_i && r_cnt == '0 && !w_hs);
        end
    end

    assign busy_o        = (r_state != IDLE);
    assign grant_o       = busy_o ? ({{(N_REQ-1){1'b0}}, 1'b1} << r_idx) : '0;
    assign grant_idx_o   = r_idx;
    assign grant_valid_o = w_gv;
    assign outst_cnt_o   = r_cnt;
    assign err_o         = r_err;
endmodule

// File: tb/tb_axi_rr_txn_arbiter.sv
// tb_axi_rr_txn_arbiter: directed scenarios for the round-robin transaction arbiter;
// each step queues the expected post-edge outputs, which are popped and checked after the edge.
module tb_axi_rr_txn_arbiter;
    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic [1:0] req_i = '0;
    logic       addr_hs_i = 1'b0;
    logic       resp_done_i = 1'b0;
    logic [1:0] grant_o;
    logic       grant_idx_o;
    logic       grant_valid_o;
    logic [2:0] outst_cnt_o;
    logic       busy_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] g;
        logic       idx;
        logic       gv;
        logic [2:0] cnt;
        logic       busy;
        logic       err;
    } obs_t;

    obs_t sb[$];

    axi_rr_txn_arbiter #(.N_REQ(2), .MAX_OUTST(4), .QUOTA(8)) dut (
        .clk(clk), .arst(arst), .req_i(req_i), .addr_hs_i(addr_hs_i),
        .resp_done_i(resp_done_i), .grant_o(grant_o), .grant_idx_o(grant_idx_o),
        .grant_valid_o(grant_valid_o), .outst_cnt_o(outst_cnt_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic obs_t e(logic [1:0] g, logic idx, logic gv, logic [2:0] c, logic er);
        obs_t x;
        x = '{g: g, idx: idx, gv: gv, cnt: c, busy: |g, err: er};
        return x;
    endfunction

    task automatic step(input logic [1:0] r, input logic h, input logic d, input obs_t x, input string tag);
        obs_t o, w;
        req_i = r;
        addr_hs_i = h;
        resp_done_i = d;
        sb.push_back(x);
        @(posedge clk);
        #1;
        o = {grant_o, grant_idx_o, grant_valid_o, outst_cnt_o, busy_o, err_o};
        w = sb.pop_front();
        checks++;
        assert (o === w) else begin
            errors++;
            $error("FAIL %s got g=%b idx=%b gv=%b cnt=%0d busy=%b err=%b exp g=%b idx=%b gv=%b cnt=%0d busy=%b err=%b",
                   tag, o.g, o.idx, o.gv, o.cnt, o.busy, o.err, w.g, w.idx, w.gv, w.cnt, w.busy, w.err);
        end
    endtask

    initial begin
        step(2'b00, 0, 0, e(2'b00, 0, 0, 0, 0), "reset");
        arst = 1'b1;
        step(2'b11, 0, 0, e(2'b01, 0, 1, 0, 0), "first_grant_m0");
        step(2'b10, 0, 0, e(2'b00, 0, 0, 0, 0), "m0_drop_idle");
        step(2'b10, 0, 0, e(2'b10, 1, 1, 0, 0), "grant_m1");
        step(2'b00, 0, 0, e(2'b00, 1, 0, 0, 0), "m1_drop_idle");
        step(2'b01, 0, 0, e(2'b01, 0, 1, 0, 0), "grant_m0_again");
        step(2'b01, 1, 0, e(2'b01, 0, 1, 1, 0), "hs1");
        step(2'b01, 1, 0, e(2'b01, 0, 1, 2, 0), "hs2");
        step(2'b01, 1, 0, e(2'b01, 0, 1, 3, 0), "hs3");
        step(2'b01, 1, 0, e(2'b01, 0, 0, 4, 0), "hs4_full");
        step(2'b01, 0, 1, e(2'b01, 0, 1, 3, 0), "resp_reopen");
        step(2'b01, 0, 1, e(2'b01, 0, 1, 2, 0), "resp_cnt2");
        step(2'b01, 1, 1, e(2'b01, 0, 1, 2, 0), "simul_q5");
        step(2'b01, 1, 1, e(2'b01, 0, 1, 2, 0), "simul_q6");
        step(2'b01, 1, 1, e(2'b01, 0, 1, 2, 0), "simul_q7");
        step(2'b01, 1, 1, e(2'b01, 0, 0, 2, 0), "quota_drain");
        step(2'b11, 0, 1, e(2'b01, 0, 0, 1, 0), "drain_ignore_req");
        step(2'b11, 0, 1, e(2'b00, 0, 0, 0, 0), "drain_to_idle");
        step(2'b11, 0, 0, e(2'b10, 1, 1, 0, 0), "fair_m1_after_quota");
        step(2'b01, 0, 0, e(2'b00, 1, 0, 0, 0), "m1_release");
        step(2'b01, 0, 0, e(2'b01, 0, 1, 0, 0), "grant_m0_drain_test");
        step(2'b01, 1, 0, e(2'b01, 0, 1, 1, 0), "d_hs1");
        step(2'b01, 1, 0, e(2'b01, 0, 1, 2, 0), "d_hs2");
        step(2'b10, 0, 0, e(2'b01, 0, 0, 2, 0), "drop_to_drain");
        step(2'b10, 0, 1, e(2'b01, 0, 0, 1, 0), "drain_resp1");
        step(2'b10, 0, 1, e(2'b00, 0, 0, 0, 0), "drain_resp2_idle");
        step(2'b10, 0, 0, e(2'b10, 1, 1, 0, 0), "grant_m1_after_drain");
        step(2'b00, 0, 0, e(2'b00, 1, 0, 0, 0), "m1_drop");
        for (int p = 0; p < 4; p++) begin
            logic       m;
            logic [1:0] oh;
            m  = p[0];
            oh = m ? 2'b10 : 2'b01;
            step(2'b11, 0, 0, e(oh, m, 1, 0, 0), $sformatf("rr_grant_p%0d", p));
            for (int k = 1; k <= 8; k++)
                step(2'b11, 1, 1, (k == 8) ? e(2'b00, m, 0, 0, 0) : e(oh, m, 1, 0, 0),
                     $sformatf("rr_p%0d_hs%0d", p, k));
        end
        step(2'b00, 0, 1, e(2'b00, 1, 0, 0, 1), "underflow_err");
        step(2'b00, 0, 0, e(2'b00, 1, 0, 0, 1), "err_sticky");
        step(2'b01, 0, 0, e(2'b01, 0, 1, 0, 1), "rst_test_grant");
        step(2'b01, 1, 0, e(2'b01, 0, 1, 1, 1), "rst_hs1");
        step(2'b01, 1, 0, e(2'b01, 0, 1, 2, 1), "rst_hs2");
        step(2'b01, 1, 0, e(2'b01, 0, 1, 3, 1), "rst_hs3");
        arst = 1'b0;
        step(2'b01, 0, 0, e(2'b00, 0, 0, 0, 0), "mid_txn_reset");
        arst = 1'b1;
        step(2'b00, 1, 0, e(2'b00, 0, 0, 0, 1), "hs_without_grant_err");
        step(2'b10, 0, 0, e(2'b10, 1, 1, 0, 1), "ptr_after_reset_m1");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
